// File: rtl/fsm_1100_pkg.sv
// Definitions shared by the 1100 pattern source and its detector: the
// transmitter state encoding and the canonical 1100 pattern.
package fsm_1100_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FINISH
    } tx_state_t;

    localparam logic [3:0] PAT_1100 = 4'b1100;

endpackage

// File: rtl/pattern_tx_1100_if.sv
// Control/status bundle of the serial pattern transmitter.
// The requester drives start/parameters; the transmitter drives the bit stream.
interface pattern_tx_1100_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic             use_default;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_default, pattern, repeat_cnt, gap_len,
        input  bit_out, bit_valid, busy, done
    );

    modport slave (
        input  start, abort, use_default, pattern, repeat_cnt, gap_len,
        output bit_out, bit_valid, busy, done
    );
endinterface

// File: rtl/pat_piso.sv
// Parallel-load, MSB-first shift register with a bit index and a last-bit flag.
// Zeros shift in from the bottom, so msb reads 0 once a whole pattern has left.
module pat_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] d,
    output logic             msb,
    output logic             last
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] shreg_reg;
    logic [PAT_W-1:0] shreg_next;
    logic [IDX_W-1:0] idx_reg;

    // Per bit: clear beats load, load beats shift.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_bit
        logic shift_in;
        if (gi == 0) begin : g_lsb
            assign shift_in = 1'b0;
        end else begin : g_upper
            assign shift_in = shreg_reg[gi-1];
        end
        assign shreg_next[gi] = clr   ? 1'b0 :
                                load  ? d[gi] :
                                shift ? shift_in : shreg_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
            idx_reg   <= '0;
        end else begin
            shreg_reg <= shreg_next;
            if (clr || load) begin
                idx_reg <= '0;
            end else if (shift) begin
                idx_reg <= last ? '0 : idx_reg + 1'b1;
            end
        end
    end

    assign msb  = shreg_reg[PAT_W-1];
    assign last = (idx_reg == IDX_W'(PAT_W - 1));
endmodule

// File: rtl/pattern_tx_1100.sv
// Serial pattern transmitter: sends a latched pattern MSB-first a given number
// of times with idle gaps between repeats; source side of the 1100 detector.
module pattern_tx_1100
    import fsm_1100_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_1100,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    pattern_tx_1100_if.slave  bus
);
    tx_state_t        state_reg, state_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [GAP_W-1:0] gap_len_reg, gap_len_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             valid_reg, busy_reg, done_reg;
    logic             sh_load, sh_shift, sh_clr, sh_last, sh_msb;
    logic [PAT_W-1:0] load_val;

    pat_piso #(.PAT_W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .clr   (sh_clr),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (load_val),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    always_comb begin
        state_next   = state_reg;
        pat_next     = pat_reg;
        rem_next     = rem_reg;
        gap_len_next = gap_len_reg;
        gap_cnt_next = gap_cnt_reg;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_clr       = 1'b0;
        load_val     = pat_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.repeat_cnt == '0) begin
                        state_next = FINISH;
                    end else begin
                        pat_next     = bus.use_default ? PAT_DEFAULT : bus.pattern;
                        rem_next     = bus.repeat_cnt;
                        gap_len_next = bus.gap_len;
                        load_val     = pat_next;
                        sh_load      = 1'b1;
                        state_next   = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.abort) begin
                    sh_clr     = 1'b1;
                    state_next = IDLE;
                end else begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        // Down-count and test for zero so a full-scale count never wraps.
                        rem_next = rem_reg - 1'b1;
                        if (rem_next == '0) begin
                            state_next = FINISH;
                        end else if (gap_len_reg == '0) begin
                            sh_load = 1'b1;
                        end else begin
                            gap_cnt_next = gap_len_reg;
                            state_next   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    sh_clr     = 1'b1;
                    state_next = IDLE;
                end else if (gap_cnt_reg == GAP_W'(1)) begin
                    gap_cnt_next = '0;
                    sh_load      = 1'b1;
                    state_next   = SEND;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the shifter output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            rem_reg     <= '0;
            gap_len_reg <= '0;
            gap_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pat_reg     <= pat_next;
            rem_reg     <= rem_next;
            gap_len_reg <= gap_len_next;
            gap_cnt_reg <= gap_cnt_next;
            valid_reg   <= (state_next == SEND);
            busy_reg    <= (state_next == SEND) || (state_next == GAP);
            done_reg    <= (state_next == FINISH);
        end
    end

    assign bus.bit_out   = sh_msb;
    assign bus.bit_valid = valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_pattern_tx_1100.sv
// Scoreboard bench for pattern_tx_1100: the driver queues expected bits and
// end-of-transfer events, the monitor checks them as the DUT emits them.
module tb_pattern_tx_1100;
    typedef struct {
        bit aborted;
        int len;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   txn_id   = 0;
    bit   exp_bits[$];
    evt_t exp_evt[$];

    pattern_tx_1100_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

    pattern_tx_1100 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic push_pattern(input logic [3:0] pat, input int reps, input int nbits_last);
        for (int r = 0; r < reps; r++) begin
            for (int b = 3; b >= 0; b--) begin
                if (r < reps - 1 || (3 - b) < nbits_last) exp_bits.push_back(pat[b]);
            end
        end
    endtask

    // Keeps the DUT until IDLE while scrambling inputs that must be ignored.
    task automatic wait_idle();
        int cyc = 0;
        while (bus.busy || bus.done) begin
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.repeat_cnt  = 8'($urandom);
            bus.pattern     = 4'($urandom);
            bus.gap_len     = 4'($urandom);
            bus.use_default = 1'($urandom);
            bus.abort       = bus.done && ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            cyc++;
            if (cyc > 5000) begin
                check("timeout", 32'(cyc), 32'd5000);
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic issue_start(input bit ud, input logic [3:0] p, input int n, input int g);
        bus.start       = 1'b1;
        bus.use_default = ud;
        bus.pattern     = p;
        bus.repeat_cnt  = 8'(n);
        bus.gap_len     = 4'(g);
        bus.abort       = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("latency_valid", 32'(bus.bit_valid), 32'(n != 0));
        check("latency_done", 32'(bus.done), 32'(n == 0));
    endtask

    task automatic send(input bit ud, input logic [3:0] p, input int n, input int g);
        logic [3:0] eff;
        evt_t e;
        eff = ud ? 4'b1100 : p;
        txn_id++;
        $display("txn %0d: use_default=%0d pattern=%b repeats=%0d gap=%0d", txn_id, ud, p, n, g);
        push_pattern(eff, n, 4);
        e.aborted = 1'b0;
        e.len     = (n == 0) ? 0 : n * 4 + (n - 1) * g;
        exp_evt.push_back(e);
        issue_start(ud, p, n, g);
        wait_idle();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    // Five repeats, aborted while the second bit of the second repeat is on the line.
    task automatic send_abort(input logic [3:0] p, input int g);
        evt_t e;
        txn_id++;
        $display("txn %0d: abort test pattern=%b repeats=5 gap=%0d", txn_id, p, g);
        push_pattern(p, 2, 2);
        e.aborted = 1'b1;
        e.len     = 6 + g;
        exp_evt.push_back(e);
        issue_start(1'b0, p, 5, g);
        for (int k = 0; k < 5 + g; k++) begin
            bus.start      = (k == 2);
            bus.repeat_cnt = 8'd1;
            bus.pattern    = ~p;
            bus.gap_len    = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_idle", {28'd0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
    endtask

    // Async reset landing mid-cycle during the first gap of a 2x1100 gap-3 transfer.
    task automatic send_reset();
        txn_id++;
        $display("txn %0d: async reset during gap", txn_id);
        push_pattern(4'b1100, 1, 4);
        issue_start(1'b1, 4'b0000, 2, 3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("in_gap_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async", {28'd0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_done", 32'(bus.done), 32'd0);
    endtask

    initial begin : monitor
        int   run_len = 0;
        bit   prev_busy = 1'b0;
        evt_t e;
        bit   b;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len   = 0;
                prev_busy = 1'b0;
                continue;
            end
            if (bus.bit_valid) begin
                if (exp_bits.size() == 0) begin
                    check("bit_extra", 32'd1, 32'd0);
                end else begin
                    b = exp_bits.pop_front();
                    check("bit", 32'(bus.bit_out), 32'(b));
                end
            end else if (bus.busy) begin
                check("gap_zero", 32'(bus.bit_out), 32'd0);
            end
            if (bus.busy) run_len++;
            if (bus.done || (prev_busy && !bus.busy)) begin
                if (exp_evt.size() == 0) begin
                    check("evt_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_evt.pop_front();
                    check("end_kind_done", 32'(bus.done), 32'(!e.aborted));
                    check("busy_len", 32'(run_len), 32'(e.len));
                end
                run_len = 0;
            end
            prev_busy = bus.busy;
        end
    end

    initial begin : driver
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.use_default = 1'b0;
        bus.pattern     = '0;
        bus.repeat_cnt  = '0;
        bus.gap_len     = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {28'd0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", {28'd0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'd0);

        send(1'b1, 4'b0000, 1, 0);
        send(1'b1, 4'b0110, 3, 0);
        send(1'b0, 4'b1010, 2, 3);
        send(1'b0, 4'b1111, 0, 5);
        send_abort(4'b1101, 0);
        send_abort(4'b1011, 2);
        send_reset();
        send(1'b1, 4'b0000, 1, 0);
        send(1'b0, 4'b0111, 255, 0);
        send(1'b0, 4'b1001, 3, 15);
        for (int i = 0; i < 30; i++) begin
            send(1'($urandom), 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 5));
        end

        repeat (4) @(posedge clk);
        #1;
        check("bits_drained", 32'(exp_bits.size()), 32'd0);
        check("evts_drained", 32'(exp_evt.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
